tcbm_device_link: RTL

Drive-side TCBM link engine. It sits directly downstream of the 1551-style 6523 port block and consumes that block's port A byte, DAV (port C bit 6) and ACK (port C bit 7) lines and status pins (port B bits 1:0). It runs the two-phase TCBM byte handshake against the host: a code byte, then a data byte. Bytes are delivered to and fetched from the local drive/SD controller over valid/ready streams.

---
 rtl/tcbm_pkg.sv | 24 ++
 rtl/tcbm_sync.sv | 24 ++
 rtl/tcbm_device_link.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/tcbm_pkg.sv
// Shared constants, state encoding and helpers for the drive-side TCBM link.
package tcbm_pkg;

   localparam logic [7:0] CODE_CMD = 8'h81;
   localparam logic [7:0] CODE_WR  = 8'h82;
   localparam logic [7:0] CODE_RD  = 8'h83;

   localparam logic [1:0] ST_OK  = 2'b00;
   localparam logic [1:0] ST_ERR = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CODE_ACK,
      S_DATA_WAIT,
      S_WR_HOLD,
      S_RD_WAIT,
      S_DONE
   } link_state_t;

   function automatic logic code_is_valid(input logic [7:0] code);
      return code inside {CODE_CMD, CODE_WR, CODE_RD};
   endfunction

endpackage

// File: rtl/tcbm_sync.sv
// N-flop synchronizer for an asynchronous level; resets to 1 so an idle
// active-low line reads as deasserted.
module tcbm_sync #(
   parameter int N = 2
) (
   input  logic clock,
   input  logic _reset,
   input  logic d,
   output logic q
);

   logic [N-1:0] chain;

   always_ff @(posedge clock or negedge _reset) begin
      if (!_reset) begin
         chain <= '1;
      end else begin
         chain <= {chain[N-2:0], d};
      end
   end

   assign q = chain[N-1];

endmodule

// File: rtl/tcbm_device_link.sv
// Drive-side TCBM link engine: two-phase code/data handshake against the host,
// bridging host bytes to local valid/ready streams.
module tcbm_device_link
   import tcbm_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 100000
) (
   input  logic       clock,
   input  logic       _reset,
   input  logic [7:0] tcbm_data_in,
   output logic [7:0] tcbm_data_out,
   output logic       tcbm_data_oe,
   input  logic       tcbm_dav,
   output logic       tcbm_ack,
   output logic [1:0] tcbm_status,
   output logic       rx_valid,
   output logic [7:0] rx_data,
   output logic       rx_is_cmd,
   input  logic       rx_ready,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   input  logic [1:0] tx_status,
   output logic       tx_ready,
   output logic       link_err
);

   localparam int              TW       = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);

   link_state_t   state, state_next;
   logic          dav_s;
   logic          timed;
   logic          tmo_fire;
   logic [TW-1:0] tmo_cnt;

   logic [7:0] code_q,   code_d;
   logic       ack_q,    ack_d;
   logic       oe_q,     oe_d;
   logic [7:0] dout_q,   dout_d;
   logic [1:0] status_q, status_d;
   logic       rxv_q,    rxv_d;
   logic [7:0] rxd_q,    rxd_d;
   logic       cmd_q,    cmd_d;
   logic       txr_q,    txr_d;
   logic       lerr_q,   lerr_d;

   tcbm_sync #(.N(SYNC_STAGES)) u_dav_sync (
      .clock  (clock),
      ._reset (_reset),
      .d      (tcbm_dav),
      .q      (dav_s)
   );

   always_ff @(posedge clock or negedge _reset) begin
      if (!_reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Timeout only fires when the host fails to move; any progress wins the tie.
   always_comb begin
      state_next = state;
      timed      = (state == S_CODE_ACK) || (state == S_DATA_WAIT) || (state == S_DONE);
      tmo_fire   = 1'b0;
      case (state)
         S_IDLE: begin
            if (!dav_s) state_next = S_CODE_ACK;
         end
         S_CODE_ACK: begin
            if (dav_s) state_next = code_is_valid(code_q) ? S_DATA_WAIT : S_IDLE;
            else if (tmo_cnt == TMO_LAST) tmo_fire = 1'b1;
         end
         S_DATA_WAIT: begin
            if (!dav_s) state_next = (code_q == CODE_RD) ? S_RD_WAIT : S_WR_HOLD;
            else if (tmo_cnt == TMO_LAST) tmo_fire = 1'b1;
         end
         S_WR_HOLD: begin
            if (rxv_q && rx_ready) state_next = S_DONE;
         end
         S_RD_WAIT: begin
            if (tx_valid) state_next = S_DONE;
         end
         S_DONE: begin
            if (dav_s) state_next = S_IDLE;
            else if (tmo_cnt == TMO_LAST) tmo_fire = 1'b1;
         end
         default: state_next = S_IDLE;
      endcase
      if (tmo_fire) state_next = S_IDLE;
   end

   always_comb begin
      code_d   = code_q;
      ack_d    = ack_q;
      oe_d     = oe_q;
      dout_d   = dout_q;
      status_d = status_q;
      rxv_d    = rxv_q;
      rxd_d    = rxd_q;
      cmd_d    = cmd_q;
      txr_d    = 1'b0;
      lerr_d   = 1'b0;
      case (state)
         S_IDLE: begin
            if (!dav_s) begin
               code_d   = tcbm_data_in;
               ack_d    = 1'b0;
               status_d = code_is_valid(tcbm_data_in) ? ST_OK : ST_ERR;
            end
         end
         S_CODE_ACK: begin
            if (dav_s) begin
               ack_d  = 1'b1;
               lerr_d = !code_is_valid(code_q);
            end
         end
         S_DATA_WAIT: begin
            if (!dav_s && code_q != CODE_RD) begin
               rxd_d    = tcbm_data_in;
               rxv_d    = 1'b1;
               cmd_d    = (code_q == CODE_CMD);
               status_d = ST_OK;
            end
         end
         S_WR_HOLD: begin
            if (rxv_q && rx_ready) begin
               rxv_d = 1'b0;
               ack_d = 1'b0;
            end
         end
         S_RD_WAIT: begin
            if (tx_valid) begin
               dout_d   = tx_data;
               status_d = tx_status;
               oe_d     = 1'b1;
               txr_d    = 1'b1;
               ack_d    = 1'b0;
            end
         end
         S_DONE: begin
            if (dav_s) begin
               ack_d = 1'b1;
               oe_d  = 1'b0;
            end
         end
         default: begin
            ack_d = 1'b1;
            oe_d  = 1'b0;
         end
      endcase
      if (tmo_fire) begin
         ack_d  = 1'b1;
         oe_d   = 1'b0;
         rxv_d  = 1'b0;
         lerr_d = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge _reset) begin
      if (!_reset) begin
         code_q   <= 8'h00;
         ack_q    <= 1'b1;
         oe_q     <= 1'b0;
         dout_q   <= 8'h00;
         status_q <= ST_OK;
         rxv_q    <= 1'b0;
         rxd_q    <= 8'h00;
         cmd_q    <= 1'b0;
         txr_q    <= 1'b0;
         lerr_q   <= 1'b0;
      end else begin
         code_q   <= code_d;
         ack_q    <= ack_d;
         oe_q     <= oe_d;
         dout_q   <= dout_d;
         status_q <= status_d;
         rxv_q    <= rxv_d;
         rxd_q    <= rxd_d;
         cmd_q    <= cmd_d;
         txr_q    <= txr_d;
         lerr_q   <= lerr_d;
      end
   end

   // Counter restarts whenever the FSM moves, so it measures time spent stuck in one state.
   always_ff @(posedge clock or negedge _reset) begin
      if (!_reset) begin
         tmo_cnt <= '0;
      end else if (!timed || state_next != state) begin
         tmo_cnt <= '0;
      end else begin
         tmo_cnt <= tmo_cnt + TW'(1);
      end
   end

   assign tcbm_ack      = ack_q;
   assign tcbm_data_oe  = oe_q;
   assign tcbm_data_out = dout_q;
   assign tcbm_status   = status_q;
   assign rx_valid      = rxv_q;
   assign rx_data       = rxd_q;
   assign rx_is_cmd     = cmd_q;
   assign tx_ready      = txr_q;
   assign link_err      = lerr_q;

endmodule
